// File: rtl/pl_fetch_ctrl_if.sv
// Fetch-stage bundle: ID-side control (redirect/stall), instruction-memory req/ack port and IF/ID outputs.
// The fetch controller takes the slave view; the surrounding pipeline/memory takes the master view.
`timescale 1ns/1ps
interface pl_fetch_ctrl_if;
    logic [1:0]  pcsrc;
    logic [31:0] bra;
    logic [31:0] jalra;
    logic [31:0] jala;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_ins;
    logic [31:0] if_pc;

    modport slave (
        input  pcsrc, bra, jalra, jala, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, if_valid, if_ins, if_pc
    );

    modport master (
        output pcsrc, bra, jalra, jala, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_ins, if_pc
    );
endinterface

// File: rtl/pl_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives imem over req/ack, feeds IF/ID with stall and redirect handling.
// Optional FETCH_PERF_EN adds saturating perf_fetch / perf_wait counters.
`timescale 1ns/1ps
module pl_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               clrn,
    pl_fetch_ctrl_if.slave     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_wait
`endif
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_FETCH = 2'b01;
    localparam logic [1:0] S_HOLD  = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic        kill_q, kill_d;
    logic [31:0] buf_ins_q, buf_ins_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_ins_q, if_ins_d;
    logic [31:0] if_pc_q, if_pc_d;

    logic        redirect;
    logic [31:0] tgt_raw;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign redirect = |bus.pcsrc;
    assign pc_inc   = pc_q + 32'd4;
    assign target   = tgt_raw & ~32'h3;

    always_comb begin
        tgt_raw = pc_inc;
        case (bus.pcsrc)
            2'b01:   tgt_raw = bus.bra;
            2'b10:   tgt_raw = bus.jalra;
            2'b11:   tgt_raw = bus.jala;
            default: tgt_raw = pc_inc;
        endcase
    end

    // Request/address decode only from state and pc so memory sees a stable address until ack.
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_ins    = if_ins_q;
    assign bus.if_pc     = if_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        kill_d     = kill_q;
        buf_ins_d  = buf_ins_q;
        buf_pc_d   = buf_pc_q;
        if_valid_d = if_valid_q;
        if_ins_d   = if_ins_q;
        if_pc_d    = if_pc_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (redirect) begin
                    pc_d       = target;
                    if_valid_d = 1'b0;
                    if_ins_d   = NOP_INS;
                end
            end

            S_FETCH: begin
                if (bus.imem_ack) begin
                    if (redirect) begin
                        pc_d       = target;
                        kill_d     = 1'b0;
                        if_valid_d = 1'b0;
                        if_ins_d   = NOP_INS;
                    end else if (kill_q) begin
                        // Wrong-path word arrives: drop it and resume from the saved target.
                        pc_d   = pend_q;
                        kill_d = 1'b0;
                        if (!bus.stall) begin
                            if_valid_d = 1'b0;
                            if_ins_d   = NOP_INS;
                        end
                    end else if (bus.stall) begin
                        buf_ins_d = bus.imem_rdata;
                        buf_pc_d  = pc_q;
                        state_d   = S_HOLD;
                    end else begin
                        if_valid_d = 1'b1;
                        if_ins_d   = bus.imem_rdata;
                        if_pc_d    = pc_q;
                        pc_d       = pc_inc;
                    end
                end else begin
                    if (redirect) begin
                        // Address must stay put until ack, so park the target until then.
                        pend_d     = target;
                        kill_d     = 1'b1;
                        if_valid_d = 1'b0;
                        if_ins_d   = NOP_INS;
                    end else if (!bus.stall) begin
                        if_valid_d = 1'b0;
                        if_ins_d   = NOP_INS;
                    end
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    pc_d       = target;
                    buf_ins_d  = NOP_INS;
                    state_d    = S_FETCH;
                    if_valid_d = 1'b0;
                    if_ins_d   = NOP_INS;
                end else if (!bus.stall) begin
                    if_valid_d = 1'b1;
                    if_ins_d   = buf_ins_q;
                    if_pc_d    = buf_pc_q;
                    pc_d       = pc_inc;
                    state_d    = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pend_q     <= RESET_PC;
            kill_q     <= 1'b0;
            buf_ins_q  <= NOP_INS;
            buf_pc_q   <= 32'h0;
            if_valid_q <= 1'b0;
            if_ins_q   <= NOP_INS;
            if_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            kill_q     <= kill_d;
            buf_ins_q  <= buf_ins_d;
            buf_pc_q   <= buf_pc_d;
            if_valid_q <= if_valid_d;
            if_ins_q   <= if_ins_d;
            if_pc_q    <= if_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_wait_q;
    logic        fetch_acc, fetch_wait;

    assign fetch_acc  = (state_q == S_FETCH) && bus.imem_ack && !kill_q && !redirect;
    assign fetch_wait = (state_q == S_FETCH) && !bus.imem_ack;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            perf_fetch_q <= 32'h0;
            perf_wait_q  <= 32'h0;
        end else begin
            if (fetch_acc && (perf_fetch_q != 32'hFFFF_FFFF))
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (fetch_wait && (perf_wait_q != 32'hFFFF_FFFF))
                perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_wait  = perf_wait_q;
`endif

endmodule
